// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one 4-bit ALU between two valid/ready requesters.
// Arbitrates (round-robin or fixed priority), captures the winner's operands,
// holds them for EXEC_CYCLES cycles, then presents a tagged, registered
// response on a valid/ready channel. Only one op is in flight at a time.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   r0_valid/a/b/op, r0_ready  requester 0 request channel (ready is combinational)
//   r1_valid/a/b/op, r1_ready  requester 1 request channel (ready is combinational)
//   resp_valid, resp_ready     response handshake
//   resp_id                    requester that issued the op
//   resp_result, resp_carry    ALU result and carry/borrow
//   busy                       high whenever an op is in flight
module alu_req_arbiter #(
  parameter bit          PRIO_FIXED  = 1'b0,
  parameter int unsigned EXEC_CYCLES = 1     // legal range 1..4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       r0_valid,
  input  logic [3:0] r0_a,
  input  logic [3:0] r0_b,
  input  logic [2:0] r0_op,
  output logic       r0_ready,
  input  logic       r1_valid,
  input  logic [3:0] r1_a,
  input  logic [3:0] r1_b,
  input  logic [2:0] r1_op,
  output logic       r1_ready,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_id,
  output logic [3:0] resp_result,
  output logic       resp_carry,
  output logic       busy
);

  localparam int unsigned DW  = 4;
  localparam int unsigned OPW = 3;
  localparam int unsigned CW  = 2;
  localparam logic [CW-1:0] CNT_LAST = CW'(EXEC_CYCLES - 1);

  typedef struct packed {
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
    logic [OPW-1:0] op;
    logic           id;
  } req_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  req_t          req_q, req_d;
  logic          last_grant_q, last_grant_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          resp_valid_q, resp_valid_d;
  logic          resp_id_q, resp_id_d;
  logic [DW-1:0] resp_result_q, resp_result_d;
  logic          resp_carry_q, resp_carry_d;
  logic          busy_q, busy_d;

  logic grant0, grant1, in_idle;

  // ALU: returns {carry, result}; add/sub use a 5-bit intermediate so bit 4
  // is the carry-out or the borrow (a < b).
  function automatic logic [DW:0] alu_eval(input req_t r);
    logic [DW:0] sum5;
    logic [DW:0] diff5;
    sum5  = {1'b0, r.a} + {1'b0, r.b};
    diff5 = {1'b0, r.a} - {1'b0, r.b};
    case (r.op)
      3'b000:  alu_eval = sum5;
      3'b001:  alu_eval = diff5;
      3'b010:  alu_eval = {1'b0, r.a & r.b};
      3'b011:  alu_eval = {1'b0, r.a | r.b};
      3'b100:  alu_eval = {1'b0, r.a ^ r.b};
      3'b101:  alu_eval = {1'b0, r.a};
      3'b110:  alu_eval = {1'b0, r.b};
      default: alu_eval = '0;
    endcase
  endfunction

  // Arbitration: a sole valid always wins; on a tie r0 wins under fixed
  // priority, otherwise the requester that was not granted last time.
  assign grant0  = r0_valid & (~r1_valid | PRIO_FIXED | last_grant_q);
  assign grant1  = r1_valid & ~grant0;
  assign in_idle = (state_q == ST_IDLE);

  assign r0_ready = in_idle & grant0;
  assign r1_ready = in_idle & grant1;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      req_q         <= '0;
      last_grant_q  <= 1'b1;
      cnt_q         <= '0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_result_q <= '0;
      resp_carry_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      last_grant_q  <= last_grant_d;
      cnt_q         <= cnt_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_result_q <= resp_result_d;
      resp_carry_q  <= resp_carry_d;
      busy_q        <= busy_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    last_grant_d  = last_grant_q;
    cnt_d         = cnt_q;
    resp_valid_d  = resp_valid_q;
    resp_id_d     = resp_id_q;
    resp_result_d = resp_result_q;
    resp_carry_d  = resp_carry_q;

    case (state_q)
      ST_IDLE: begin
        if (r0_ready || r1_ready) begin
          req_d.a      = r1_ready ? r1_a  : r0_a;
          req_d.b      = r1_ready ? r1_b  : r0_b;
          req_d.op     = r1_ready ? r1_op : r0_op;
          req_d.id     = r1_ready;
          last_grant_d = r1_ready;
          cnt_d        = '0;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          {resp_carry_d, resp_result_d} = alu_eval(req_q);
          resp_id_d    = req_q.id;
          resp_valid_d = 1'b1;
          state_d      = ST_RESP;
        end
      end
      ST_RESP: begin
        // Response registers hold until the consumer takes them.
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_result = resp_result_q;
  assign resp_carry  = resp_carry_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter: three instances share one stimulus set
// (round-robin EXEC_CYCLES=1, fixed-priority EXEC_CYCLES=1, round-robin
// EXEC_CYCLES=4). Inputs change 1 time unit after posedge, outputs are sampled
// on negedge.
module tb_alu_req_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       r0_valid, r1_valid, resp_ready;
  logic [3:0] r0_a, r0_b, r1_a, r1_b;
  logic [2:0] r0_op, r1_op;

  logic       a_r0_ready, a_r1_ready, a_resp_valid, a_resp_id, a_resp_carry, a_busy;
  logic [3:0] a_resp_result;
  logic       f_r0_ready, f_r1_ready, f_resp_valid, f_resp_id, f_resp_carry, f_busy;
  logic [3:0] f_resp_result;
  logic       e_r0_ready, e_r1_ready, e_resp_valid, e_resp_id, e_resp_carry, e_busy;
  logic [3:0] e_resp_result;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  alu_req_arbiter #(.PRIO_FIXED(1'b0), .EXEC_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op), .r0_ready(a_r0_ready),
    .r1_valid(r1_valid), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op), .r1_ready(a_r1_ready),
    .resp_valid(a_resp_valid), .resp_ready(resp_ready), .resp_id(a_resp_id),
    .resp_result(a_resp_result), .resp_carry(a_resp_carry), .busy(a_busy)
  );

  alu_req_arbiter #(.PRIO_FIXED(1'b1), .EXEC_CYCLES(1)) dut_fx (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op), .r0_ready(f_r0_ready),
    .r1_valid(r1_valid), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op), .r1_ready(f_r1_ready),
    .resp_valid(f_resp_valid), .resp_ready(resp_ready), .resp_id(f_resp_id),
    .resp_result(f_resp_result), .resp_carry(f_resp_carry), .busy(f_busy)
  );

  alu_req_arbiter #(.PRIO_FIXED(1'b0), .EXEC_CYCLES(4)) dut_e4 (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op), .r0_ready(e_r0_ready),
    .r1_valid(r1_valid), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op), .r1_ready(e_r1_ready),
    .resp_valid(e_resp_valid), .resp_ready(resp_ready), .resp_id(e_resp_id),
    .resp_result(e_resp_result), .resp_carry(e_resp_carry), .busy(e_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one op on a single requester with resp_ready=1 and check the response.
  task automatic run_single(input bit id, input logic [3:0] a, input logic [3:0] b,
                            input logic [2:0] op, input logic [3:0] er, input logic ec,
                            input string tag);
    int n;
    if (id) begin
      r1_valid = 1'b1; r1_a = a; r1_b = b; r1_op = op;
    end else begin
      r0_valid = 1'b1; r0_a = a; r0_b = b; r0_op = op;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk({tag, ".ready"}, id ? a_r1_ready : a_r0_ready, 1);
    next_cycle();
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!a_resp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".latency"}, n, 1);
    chk({tag, ".id"}, a_resp_id, id);
    chk({tag, ".result"}, a_resp_result, er);
    chk({tag, ".carry"}, a_resp_carry, ec);
    chk({tag, ".fx_result"}, {f_resp_carry, f_resp_result}, {ec, er});
    next_cycle();
    @(negedge clk);
    chk({tag, ".drop"}, {a_resp_valid, a_busy}, 0);
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    logic exp_id;
    rst = 1'b1;
    r0_valid = 1'b0; r0_a = '0; r0_b = '0; r0_op = '0;
    r1_valid = 1'b0; r1_a = '0; r1_b = '0; r1_op = '0;
    resp_ready = 1'b0;

    // Reset state
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rst.busy", {a_busy, f_busy, e_busy}, 0);
    chk("rst.resp_valid", {a_resp_valid, f_resp_valid, e_resp_valid}, 0);
    chk("rst.resp", {a_resp_id, a_resp_result, a_resp_carry}, 0);
    next_cycle();
    rst = 1'b0;

    // Single ops: add with carry, sub with borrow, logic ops, boundaries
    run_single(1'b0, 4'd9, 4'd8, 3'b000, 4'd1, 1'b1, "add9_8");
    run_single(1'b1, 4'd3, 4'd5, 3'b001, 4'd14, 1'b1, "sub3_5");
    run_single(1'b1, 4'd5, 4'd3, 3'b001, 4'd2, 1'b0, "sub5_3");
    run_single(1'b0, 4'd7, 4'd8, 3'b000, 4'd15, 1'b0, "add7_8");
    run_single(1'b0, 4'hF, 4'h1, 3'b000, 4'd0, 1'b1, "addF_1");
    run_single(1'b0, 4'd4, 4'd4, 3'b001, 4'd0, 1'b0, "sub4_4");
    run_single(1'b0, 4'hC, 4'hA, 3'b010, 4'h8, 1'b0, "and");
    run_single(1'b1, 4'hC, 4'hA, 3'b011, 4'hE, 1'b0, "or");
    run_single(1'b0, 4'hC, 4'hA, 3'b101, 4'hC, 1'b0, "pass_a");
    run_single(1'b1, 4'hC, 4'hA, 3'b110, 4'hA, 1'b0, "pass_b");
    run_single(1'b0, 4'hC, 4'hA, 3'b111, 4'h0, 1'b0, "zero");

    // Both valid continuously: round-robin 0,1,0,1 and fixed 0,0,0,0
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    r0_valid = 1'b1; r0_a = 4'd1; r0_b = 4'd1; r0_op = 3'b000;
    r1_valid = 1'b1; r1_a = 4'd2; r1_b = 4'd2; r1_op = 3'b000;
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_id = 1'((i % 2) != 0);
      @(negedge clk);
      chk($sformatf("tie%0d.rr_ready", i), {a_r0_ready, a_r1_ready}, {~exp_id, exp_id});
      chk($sformatf("tie%0d.fx_ready", i), {f_r0_ready, f_r1_ready}, 2'b10);
      next_cycle();
      @(negedge clk);
      next_cycle();
      @(negedge clk);
      chk($sformatf("tie%0d.rr_resp", i), {a_resp_valid, a_resp_id, a_resp_result},
          {1'b1, exp_id, exp_id ? 4'd4 : 4'd2});
      chk($sformatf("tie%0d.fx_resp", i), {f_resp_valid, f_resp_id, f_resp_result},
          {1'b1, 1'b0, 4'd2});
      next_cycle();
    end
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    next_cycle();

    // Backpressure: response held for 5 cycles while r1 waits
    r0_valid = 1'b1; r0_a = 4'd5; r0_b = 4'd3; r0_op = 3'b100;
    resp_ready = 1'b0;
    @(negedge clk);
    chk("bp.r0_ready", a_r0_ready, 1);
    next_cycle();
    r0_valid = 1'b0;
    r1_valid = 1'b1; r1_a = 4'd6; r1_b = 4'd3; r1_op = 3'b010;
    @(negedge clk);
    chk("bp.exec_r1_ready", a_r1_ready, 0);
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp%0d.hold", i), {a_resp_valid, a_resp_id, a_resp_result, a_resp_carry},
          {1'b1, 1'b0, 4'd6, 1'b0});
      chk($sformatf("bp%0d.r1_ready", i), a_r1_ready, 0);
      next_cycle();
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp.release_cycle", {a_resp_valid, a_r1_ready}, 2'b10);
    next_cycle();
    @(negedge clk);
    chk("bp.r1_granted", {a_r1_ready, a_resp_valid}, 2'b10);
    next_cycle();
    r1_valid = 1'b0;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    chk("bp.r1_resp", {a_resp_valid, a_resp_id, a_resp_result}, {1'b1, 1'b1, 4'd2});
    next_cycle();

    // Reset during EXEC kills the op
    r0_valid = 1'b1; r0_a = 4'd9; r0_b = 4'd8; r0_op = 3'b000;
    @(negedge clk);
    chk("kill.ready", a_r0_ready, 1);
    next_cycle();
    r0_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("kill.exec_busy", a_busy, 1);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("kill.cleared", {a_busy, a_resp_valid, a_resp_id, a_resp_result, a_resp_carry}, 0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (a_resp_valid) seen++;
    end
    chk("kill.no_resp", seen, 0);
    next_cycle();

    // EXEC_CYCLES=4 latency: xor A^6
    r0_valid = 1'b1; r0_a = 4'hA; r0_b = 4'h6; r0_op = 3'b100;
    resp_ready = 1'b0;
    @(negedge clk);
    chk("e4.ready", {e_r0_ready, e_r1_ready}, 2'b10);
    next_cycle();
    r0_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk($sformatf("e4.valid_c%0d", c), e_resp_valid, (c == 5) ? 1 : 0);
      if (c < 5) begin
        chk($sformatf("e4.busy_c%0d", c), e_busy, 1);
        next_cycle();
      end
    end
    chk("e4.resp", {e_resp_id, e_resp_result, e_resp_carry}, {1'b0, 4'hC, 1'b0});
    resp_ready = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("e4.drop", {e_resp_valid, e_busy}, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
